rom_read_arbiter: RTL
=====================

Name: rom_read_arbiter

Overview:
- Shares the single combinational instruction-ROM read port between two requesters.
  - Port 0: instruction fetch, high priority, single-word reads.
  - Port 1: debug/boot-copy reader, low priority, burst reads.
- Issues exactly one ROM read per cycle and returns registered data one cycle later.
- A starvation guard bounds how long port 1 can be locked out.
- Sits between the fetch stage / debug unit and the ROM.

Parameters:
- ROM_SIZE, 32, number of 32-bit ROM words; word index = addr[30:2].
- STARVE_LIMIT, 4, consecutive cycles port 1 may be denied before it is forced to win (legal range 1..15).

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous active-high reset
- p0_req  in  1  fetch read request
- p0_addr  in  31  fetch byte address
- p0_gnt  out  1  fetch request issued to ROM this cycle
- p0_rvalid  out  1  fetch read data valid (1-cycle pulse)
- p0_rdata  out  32  fetch read data
- p0_err  out  1  address out of range, qualified by p0_rvalid
- p1_req  in  1  burst request, sampled only in IDLE
- p1_addr  in  31  burst base byte address
- p1_len  in  6  burst length minus 1 (0 = 1 word, 63 = 64 words)
- p1_gnt  out  1  first beat of burst issued this cycle
- p1_busy  out  1  burst in progress (BURST state)
- p1_rvalid  out  1  burst beat data valid (1-cycle pulse)
- p1_rdata  out  32  burst beat data
- p1_err  out  1  beat address out of range, qualified by p1_rvalid
- p1_last  out  1  final beat, qualified by p1_rvalid
- rom_addr  out  31  address driven to ROM
- rom_data  in  32  ROM read data, combinational from rom_addr

Behaviour:
- Reset (asynchronous, any time):
  - All registered outputs go to 0; state goes to IDLE; starve_cnt, beat counter and burst address clear.
  - A burst in flight is aborted: no further rvalid or last pulses.
- Port 1 activity: p1_act = (state==BURST) | (state==IDLE & p1_req).
- Winner selection, combinational, one per cycle:
  - Port 1 wins if p1_act & (!p0_req | starve_cnt==STARVE_LIMIT).
  - Otherwise port 0 wins if p0_req.
  - Otherwise no winner.
- rom_addr:
  - port 0 winner → p0_addr;
  - port 1 winner in IDLE → p1_addr;
  - port 1 winner in BURST → burst address register;
  - no winner → 0.
- p0_gnt = port 0 wins. Port 0 requester holds p0_req and p0_addr until it sees p0_gnt; it may re-request in the next cycle for back-to-back reads.
- p1_gnt = port 1 wins while in IDLE. This is a single pulse per burst.
- State machine IDLE/BURST:
  - IDLE → BURST when port 1 wins and p1_len != 0; latch burst address = p1_addr+4 and remaining = p1_len.
  - IDLE with p1_len == 0: the single beat is issued and the state stays IDLE.
  - BURST, each port-1 win: burst address += 4 (wraps mod 2^31); remaining -= 1.
  - BURST → IDLE on the win that issues the final beat (remaining==1 before decrement).
  - p1_req is ignored while in BURST. The next burst can be granted at the earliest in the cycle after returning to IDLE.
  - p1_busy = (state==BURST).
- starve_cnt (4-bit):
  - Increments, saturating at STARVE_LIMIT, each cycle p1_act is high and port 0 wins.
  - Clears when port 1 wins or p1_act is low.
- Response path, latency 1:
  - The cycle after a port-N issue: pN_rvalid=1, pN_rdata = registered rom_data, pN_err = registered (word index >= ROM_SIZE).
  - When err=1, rdata is forced to 0.
  - p1_last=1 with the beat that was final when issued.
  - rdata and err hold their value until the next response for that port; rvalid and last are 0 otherwise.
- Both ports can never have rvalid in the same cycle.
- STARVE_LIMIT values outside 1..15 are illegal; the implementation flags this with a simulation-time assertion.

Test Plan:
- ROM model: word i = 32'hA500_0000+i.
  - p0_req held with addr 0x8 for 3 cycles, p1 idle → p0_gnt on 3 cycles; p0_rvalid one cycle after each grant; p0_rdata=0xA5000002.
- p1 single beat: p1_req, addr 0x10, len 0, p0 idle → p1_gnt for 1 cycle, p1_busy stays 0; next cycle p1_rvalid=1, p1_last=1, p1_rdata=0xA5000004.
- p1 burst: addr 0x0, len 3, p0 idle:
  - rom_addr sequence 0x0, 0x4, 0x8, 0xC on consecutive cycles;
  - rdata sequence 0xA5000000..3 with p1_last only on the 4th beat;
  - p1_busy high for 3 cycles.
- Starvation, STARVE_LIMIT=4: p0_req held continuously while a 2-beat burst is pending → pattern p0,p0,p0,p0,p1,p0,p0,p0,p0,p1; starve_cnt clears after each p1 win.
- Out of range: p0 addr 0x80 (word 32) → p0_rvalid=1, p0_err=1, p0_rdata=0. Burst at addr 0x7C, len 1 → beat 0 err=0 with data 0xA500001F, beat 1 err=1.
- Reset asserted mid-burst (addr 0, len 7, after 3 beats) → outputs 0 immediately, no further p1_rvalid. After release, a new p1_req is granted from IDLE.

Source files
------------

// File: rtl/rom_read_arbiter.sv
// rom_read_arbiter
//   Shares one combinational instruction-ROM read port between two requesters.
//   Port 0 (instruction fetch) has priority and issues single-word reads.
//   Port 1 (debug / boot copy) issues bursts of 1..64 words. A starvation
//   counter forces port 1 to win after STARVE_LIMIT consecutive denied cycles.
//   One ROM read is issued per cycle; the data comes back registered one cycle
//   later on the port that issued it.
//
// Ports
//   clk, reset             : clock (rising edge), asynchronous active-high reset
//   p0_req/p0_addr         : fetch request and byte address (held until p0_gnt)
//   p0_gnt                 : fetch read issued to the ROM this cycle
//   p0_rvalid/rdata/err    : fetch response, one cycle after p0_gnt
//   p1_req/p1_addr/p1_len  : burst request, base byte address, length-1
//                            (sampled only while idle)
//   p1_gnt                 : first beat of a burst issued this cycle
//   p1_busy                : burst in progress after its first beat
//   p1_rvalid/rdata/err/last : burst beat response, one cycle after issue
//   rom_addr/rom_data      : ROM address out, combinational ROM data in
module rom_read_arbiter #(
  parameter int ROM_SIZE     = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        p0_req,
  input  logic [30:0] p0_addr,
  output logic        p0_gnt,
  output logic        p0_rvalid,
  output logic [31:0] p0_rdata,
  output logic        p0_err,
  input  logic        p1_req,
  input  logic [30:0] p1_addr,
  input  logic [5:0]  p1_len,
  output logic        p1_gnt,
  output logic        p1_busy,
  output logic        p1_rvalid,
  output logic [31:0] p1_rdata,
  output logic        p1_err,
  output logic        p1_last,
  output logic [30:0] rom_addr,
  input  logic [31:0] rom_data
);

  localparam logic [3:0]  LIMIT     = 4'(STARVE_LIMIT);
  localparam logic [31:0] ROM_WORDS = 32'(ROM_SIZE);

  typedef enum logic {IDLE, BURST} state_t;

  state_t      state_q, state_d;
  logic [30:0] burst_addr_q, burst_addr_d;   // address of the next burst beat
  logic [5:0]  remaining_q, remaining_d;     // beats still to issue in BURST
  logic [3:0]  starve_q, starve_d;
  logic        p0_rvalid_q, p0_rvalid_d;
  logic [31:0] p0_rdata_q, p0_rdata_d;
  logic        p0_err_q, p0_err_d;
  logic        p1_rvalid_q, p1_rvalid_d;
  logic [31:0] p1_rdata_q, p1_rdata_d;
  logic        p1_err_q, p1_err_d;
  logic        p1_last_q, p1_last_d;

  logic        p1_act, p1_win, p0_win, issue_last, oob;
  logic [31:0] rdata_masked;

  always_comb begin
    p1_act = (state_q == BURST) | ((state_q == IDLE) & p1_req);
    p1_win = p1_act & (~p0_req | (starve_q == LIMIT));
    p0_win = p0_req & ~p1_win;

    // Beat being issued by port 1 is the final one of its burst
    issue_last = (state_q == IDLE) ? (p1_len == 6'd0) : (remaining_q == 6'd1);

    if (p0_win)                 rom_addr = p0_addr;
    else if (p1_win && state_q == IDLE) rom_addr = p1_addr;
    else if (p1_win)            rom_addr = burst_addr_q;
    else                        rom_addr = 31'd0;

    oob          = ({3'b000, rom_addr[30:2]} >= ROM_WORDS);
    rdata_masked = oob ? 32'd0 : rom_data;

    state_d      = state_q;
    burst_addr_d = burst_addr_q;
    remaining_d  = remaining_q;
    if (p1_win) begin
      if (state_q == IDLE) begin
        if (p1_len != 6'd0) begin
          state_d      = BURST;
          burst_addr_d = p1_addr + 31'd4;
          remaining_d  = p1_len;
        end
      end else begin
        burst_addr_d = burst_addr_q + 31'd4;   // wraps mod 2^31
        remaining_d  = remaining_q - 6'd1;
        if (remaining_q == 6'd1) state_d = IDLE;
      end
    end

    // Count only cycles where port 1 wanted the ROM and fetch took it
    if (p1_act && p0_win) starve_d = (starve_q == LIMIT) ? starve_q : starve_q + 4'd1;
    else                  starve_d = 4'd0;

    p0_rvalid_d = p0_win;
    p0_rdata_d  = p0_win ? rdata_masked : p0_rdata_q;
    p0_err_d    = p0_win ? oob : p0_err_q;
    p1_rvalid_d = p1_win;
    p1_rdata_d  = p1_win ? rdata_masked : p1_rdata_q;
    p1_err_d    = p1_win ? oob : p1_err_q;
    p1_last_d   = p1_win & issue_last;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      burst_addr_q <= '0;
      remaining_q  <= '0;
      starve_q     <= '0;
      p0_rvalid_q  <= 1'b0;
      p0_rdata_q   <= '0;
      p0_err_q     <= 1'b0;
      p1_rvalid_q  <= 1'b0;
      p1_rdata_q   <= '0;
      p1_err_q     <= 1'b0;
      p1_last_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      burst_addr_q <= burst_addr_d;
      remaining_q  <= remaining_d;
      starve_q     <= starve_d;
      p0_rvalid_q  <= p0_rvalid_d;
      p0_rdata_q   <= p0_rdata_d;
      p0_err_q     <= p0_err_d;
      p1_rvalid_q  <= p1_rvalid_d;
      p1_rdata_q   <= p1_rdata_d;
      p1_err_q     <= p1_err_d;
      p1_last_q    <= p1_last_d;
    end
  end

  assign p0_gnt    = p0_win;
  assign p1_gnt    = p1_win & (state_q == IDLE);
  assign p1_busy   = (state_q == BURST);
  assign p0_rvalid = p0_rvalid_q;
  assign p0_rdata  = p0_rdata_q;
  assign p0_err    = p0_err_q;
  assign p1_rvalid = p1_rvalid_q;
  assign p1_rdata  = p1_rdata_q;
  assign p1_err    = p1_err_q;
  assign p1_last   = p1_last_q;

  // A limit of 0 would never let fetch in; above 15 overflows the counter
  always @(posedge clk) begin
    assert (STARVE_LIMIT >= 1 && STARVE_LIMIT <= 15)
      else $error("rom_read_arbiter: STARVE_LIMIT %0d outside 1..15", STARVE_LIMIT);
  end

endmodule
